// File: rtl/tmds_encoder_if.sv
// Pixel-side bundle for the TMDS encoder: sync/data inputs and the three 10-bit channel symbols.
interface tmds_encoder_if;
  logic        VDEn_i;
  logic        hSync_i;
  logic        vSync_i;
  logic [23:0] pixel_i;
  logic [9:0]  tmdsRed_o;
  logic [9:0]  tmdsGreen_o;
  logic [9:0]  tmdsBlue_o;

  modport master (
    output VDEn_i, hSync_i, vSync_i, pixel_i,
    input  tmdsRed_o, tmdsGreen_o, tmdsBlue_o
  );

  modport slave (
    input  VDEn_i, hSync_i, vSync_i, pixel_i,
    output tmdsRed_o, tmdsGreen_o, tmdsBlue_o
  );
endinterface

// File: rtl/tmds_encoder.sv
// DVI 1.0 TMDS encoder: 2-stage pipeline (transition minimisation, then DC balance),
// one running-disparity counter per channel. Channel 0 = blue, 1 = green, 2 = red.
module tmds_encoder #(
  parameter bit INVERT_SYNC = 1'b0
) (
  input  logic          pixclk_i,
  input  logic          rstn_i,
  tmds_encoder_if.slave bus
);

  logic        de_q;
  logic        c0_q;
  logic        c1_q;
  logic [29:0] sym_all;

  always_ff @(posedge pixclk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      de_q <= 1'b0;
      c0_q <= 1'b0;
      c1_q <= 1'b0;
    end else begin
      de_q <= bus.VDEn_i;
      c0_q <= bus.hSync_i ^ INVERT_SYNC;
      c1_q <= bus.vSync_i ^ INVERT_SYNC;
    end
  end

  for (genvar gi = 0; gi < 3; gi++) begin : g_ch
    logic [7:0]        d;
    logic [8:0]        qm_d;
    logic [8:0]        qm_q;
    logic [9:0]        sym_d;
    logic [9:0]        sym_q;
    logic signed [4:0] cnt_d;
    logic signed [4:0] cnt_q;
    logic [1:0]        ctl;

    assign d   = bus.pixel_i[8*gi +: 8];
    // Only the blue channel carries sync; green/red always send the 00 token.
    assign ctl = (gi == 0) ? {c1_q, c0_q} : 2'b00;

    always_comb begin : stage1
      logic [3:0] ones;
      logic       use_xnor;
      logic [8:0] qm;
      ones = 4'd0;
      for (int i = 0; i < 8; i++) begin
        ones = ones + {3'd0, d[i]};
      end
      use_xnor = (ones > 4'd4) || ((ones == 4'd4) && !d[0]);
      qm       = 9'd0;
      qm[0]    = d[0];
      for (int i = 1; i < 8; i++) begin
        qm[i] = use_xnor ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
      end
      qm[8] = ~use_xnor;
      qm_d  = qm;
    end

    // 5-bit two's-complement sums may wrap in intermediates, but every reachable
    // final count lies in -8..+8, so the modulo-32 result is exact.
    always_comb begin : stage2
      logic [3:0]        n1;
      logic signed [4:0] diff;
      logic              q8;
      n1 = 4'd0;
      for (int i = 0; i < 8; i++) begin
        n1 = n1 + {3'd0, qm_q[i]};
      end
      diff  = $signed({n1, 1'b0}) - 5'sd8;
      q8    = qm_q[8];
      sym_d = 10'h354;
      cnt_d = 5'sd0;
      if (!de_q) begin
        case (ctl)
          2'b00:   sym_d = 10'h354;
          2'b01:   sym_d = 10'h0AB;
          2'b10:   sym_d = 10'h154;
          default: sym_d = 10'h2AB;
        endcase
        cnt_d = 5'sd0;
      end else if ((cnt_q == 5'sd0) || (diff == 5'sd0)) begin
        sym_d = {~q8, q8, q8 ? qm_q[7:0] : ~qm_q[7:0]};
        cnt_d = q8 ? (cnt_q + diff) : (cnt_q - diff);
      end else if (((cnt_q > 5'sd0) && (diff > 5'sd0)) ||
                   ((cnt_q < 5'sd0) && (diff < 5'sd0))) begin
        sym_d = {1'b1, q8, ~qm_q[7:0]};
        cnt_d = cnt_q - diff + (q8 ? 5'sd2 : 5'sd0);
      end else begin
        sym_d = {1'b0, q8, qm_q[7:0]};
        cnt_d = cnt_q + diff - (q8 ? 5'sd0 : 5'sd2);
      end
    end

    always_ff @(posedge pixclk_i or negedge rstn_i) begin
      if (!rstn_i) begin
        qm_q  <= 9'd0;
        sym_q <= 10'h354;
        cnt_q <= 5'sd0;
      end else begin
        qm_q  <= qm_d;
        sym_q <= sym_d;
        cnt_q <= cnt_d;
      end
    end

    assign sym_all[10*gi +: 10] = sym_q;
  end

  assign bus.tmdsBlue_o  = sym_all[9:0];
  assign bus.tmdsGreen_o = sym_all[19:10];
  assign bus.tmdsRed_o   = sym_all[29:20];

endmodule

// File: tb/tb_tmds_encoder.sv
// Directed and model-checked stimulus for tmds_encoder: reset, control tokens,
// DC balance corner cases, a 640-pixel active line and an asynchronous mid-line reset.
module tb_tmds_encoder;
  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  tmds_encoder_if bus();

  tmds_encoder #(.INVERT_SYNC(1'b0)) dut (
    .pixclk_i (clk),
    .rstn_i   (rstn),
    .bus      (bus)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic de, input logic hs, input logic vs, input logic [23:0] pix);
    bus.VDEn_i  = de;
    bus.hSync_i = hs;
    bus.vSync_i = vs;
    bus.pixel_i = pix;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic [9:0] exp);
    check({tag, "_red"},   {22'd0, bus.tmdsRed_o},   {22'd0, exp});
    check({tag, "_green"}, {22'd0, bus.tmdsGreen_o}, {22'd0, exp});
    check({tag, "_blue"},  {22'd0, bus.tmdsBlue_o},  {22'd0, exp});
  endtask

  // Reference encoder written directly from the DVI 1.0 algorithm, using plain integers.
  task automatic ref_enc(input logic [7:0] d, input int cnt_in,
                         output logic [9:0] sym, output int cnt_out);
    int   n1d, n1, n0, q8;
    logic xnor_sel;
    logic [8:0] qm;
    n1d      = $countones(d);
    xnor_sel = (n1d > 4) || (n1d == 4 && d[0] == 1'b0);
    qm[0]    = d[0];
    for (int i = 1; i < 8; i++)
      qm[i] = xnor_sel ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
    qm[8] = !xnor_sel;
    n1 = $countones(qm[7:0]);
    n0 = 8 - n1;
    q8 = qm[8] ? 1 : 0;
    cnt_out = cnt_in;
    if (cnt_in == 0 || n1 == n0) begin
      sym     = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
      cnt_out = cnt_in + (qm[8] ? (n1 - n0) : (n0 - n1));
    end else if ((cnt_in > 0 && n1 > n0) || (cnt_in < 0 && n0 > n1)) begin
      sym     = {1'b1, qm[8], ~qm[7:0]};
      cnt_out = cnt_in + 2 * q8 + (n0 - n1);
    end else begin
      sym     = {1'b0, qm[8], qm[7:0]};
      cnt_out = cnt_in + (n1 - n0) - 2 * (1 - q8);
    end
  endtask

  function automatic logic [7:0] dec(input logic [9:0] s);
    logic [7:0] q;
    logic [7:0] d;
    q    = s[9] ? ~s[7:0] : s[7:0];
    d[0] = q[0];
    for (int i = 1; i < 8; i++)
      d[i] = s[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
    return d;
  endfunction

  function automatic logic [9:0] out_ch(input int c);
    return (c == 0) ? bus.tmdsBlue_o : (c == 1) ? bus.tmdsGreen_o : bus.tmdsRed_o;
  endfunction

  logic [9:0]  tok_exp [4];
  logic [3:0]  hs_pat;
  logic [3:0]  vs_pat;
  int          mc [3];
  int          sum [3];
  int          maxabs;
  logic [9:0]  e_cur [3];
  logic [9:0]  e_prev [3];
  logic [23:0] pix;
  logic [23:0] p_prev;

  initial begin
    tok_exp = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};
    hs_pat  = 4'b1010;
    vs_pat  = 4'b1100;

    // Reset held with active white input
    rstn = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 24'hFFFFFF);
    repeat (3) tick();
    check_all("rst_hold", 10'h354);
    $display("reset held: red=%h green=%h blue=%h", bus.tmdsRed_o, bus.tmdsGreen_o, bus.tmdsBlue_o);
    rstn = 1'b1;
    tick();
    check_all("rst_rel_lat1", 10'h354);
    tick();
    check_all("white_first", 10'h200);
    $display("white from cnt=0: blue=%h", bus.tmdsBlue_o);
    drive(1'b0, 1'b0, 1'b0, 24'h0);
    tick();
    check_all("white_second", 10'h0FF);
    tick();

    // Control tokens, each emerging exactly two cycles after its input
    for (int k = 0; k <= 4; k++) begin
      if (k < 4) drive(1'b0, hs_pat[k], vs_pat[k], 24'h0);
      else       drive(1'b0, 1'b0, 1'b0, 24'h0);
      tick();
      if (k > 0) begin
        check($sformatf("tok%0d_blue", k - 1), {22'd0, bus.tmdsBlue_o}, {22'd0, tok_exp[k-1]});
        check($sformatf("tok%0d_red", k - 1), {22'd0, bus.tmdsRed_o}, 32'h354);
        check($sformatf("tok%0d_green", k - 1), {22'd0, bus.tmdsGreen_o}, 32'h354);
        $display("control h=%0b v=%0b: blue=%h", hs_pat[k-1], vs_pat[k-1], bus.tmdsBlue_o);
      end
    end
    tick();

    // Black pixels: cnt 0 -> -8 -> +2
    drive(1'b1, 1'b0, 1'b0, 24'h000000);
    tick();
    tick();
    check_all("black1", 10'h100);
    drive(1'b0, 1'b0, 1'b0, 24'h0);
    tick();
    check_all("black2", 10'h3FF);
    $display("black pair: second blue=%h", bus.tmdsBlue_o);
    tick();
    tick();

    // 640-pixel random active line against the reference model
    for (int c = 0; c < 3; c++) begin
      mc[c]  = 0;
      sum[c] = 0;
    end
    maxabs = 0;
    p_prev = 24'h0;
    for (int n = 0; n <= 640; n++) begin
      if (n < 640) begin
        pix = 24'($urandom);
        drive(1'b1, 1'b0, 1'b0, pix);
        for (int c = 0; c < 3; c++)
          ref_enc(pix[8*c +: 8], mc[c], e_cur[c], mc[c]);
      end else begin
        pix = 24'h0;
        drive(1'b0, 1'b0, 1'b0, pix);
      end
      tick();
      if (n > 0) begin
        for (int c = 0; c < 3; c++) begin
          check($sformatf("line_px%0d_ch%0d", n - 1, c), {22'd0, out_ch(c)}, {22'd0, e_prev[c]});
          sum[c] = sum[c] + 2 * $countones(out_ch(c)) - 10;
          if (sum[c] > maxabs)  maxabs = sum[c];
          if (-sum[c] > maxabs) maxabs = -sum[c];
        end
        check($sformatf("line_dec%0d", n - 1),
              {8'd0, dec(bus.tmdsRed_o), dec(bus.tmdsGreen_o), dec(bus.tmdsBlue_o)},
              {8'd0, p_prev});
      end
      e_prev = e_cur;
      p_prev = pix;
    end
    for (int c = 0; c < 3; c++) begin
      check($sformatf("line_sum_ch%0d", c), sum[c], mc[c]);
      check($sformatf("line_end_bal_ch%0d", c), {31'd0, (sum[c] <= 8 && sum[c] >= -8)}, 32'd1);
    end
    check("line_max_disparity", {31'd0, (maxabs <= 12)}, 32'd1);
    $display("random line: 640 pixels, max |disparity|=%0d, end sums %0d/%0d/%0d",
             maxabs, sum[2], sum[1], sum[0]);
    tick();
    tick();

    // Asynchronous reset in the middle of active video
    drive(1'b1, 1'b0, 1'b0, 24'h000000);
    tick();
    drive(1'b1, 1'b0, 1'b0, 24'hFFFFFF);
    tick();
    check_all("mid_pre", 10'h100);
    #3;
    rstn = 1'b0;
    #1;
    check_all("mid_async", 10'h354);
    $display("mid-line reset: blue=%h before next edge", bus.tmdsBlue_o);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 24'h000000);
    tick();
    check_all("mid_rel_lat1", 10'h354);
    tick();
    check_all("mid_black", 10'h100);
    $display("after mid-line reset: black blue=%h", bus.tmdsBlue_o);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/tmds_encoder.md
Name: tmds_encoder

Overview:
- Downstream neighbour of the video timing/pixel stage. Converts each pixel-clock cycle's {VDEn, hSync, vSync, 24-bit RGB} into three 10-bit DVI 1.0 TMDS symbols (red, green, blue channels).
- Output words feed the 10:1 serializer/OSERDES wrapper.
- Pure pixel-clock domain, fixed 2-cycle pipeline, one DC-balance running-disparity counter per channel.

Parameters:
- INVERT_SYNC, 0, when 1 hSync_i/vSync_i are inverted before encoding (negative-polarity sync modes).

Ports:
- pixclk_i  in  1  pixel clock; all logic on rising edge.
- rstn_i  in  1  reset, asynchronous, active-low.
- VDEn_i  in  1  video data enable; 1 = active pixel, 0 = blanking/control period.
- hSync_i  in  1  horizontal sync, active-high.
- vSync_i  in  1  vertical sync, active-high.
- pixel_i  in  24  {red[23:16], green[15:8], blue[7:0]}.
- tmdsRed_o  out  10  channel 2 symbol.
- tmdsGreen_o  out  10  channel 1 symbol.
- tmdsBlue_o  out  10  channel 0 symbol.
- All symbols are bit 0 first on the wire.

Behaviour:
- Reset (rstn_i low, asynchronous):
  - All three outputs = 10'h354 (control token C1C0=00).
  - Disparity counters = 0; pipeline registers cleared (DE=0, syncs=0, data=0).
  - Deassertion takes effect on the next pixclk_i edge.
- Reset mid-line: outputs immediately return to 10'h354 and counters to 0. The first input after release is encoded from cnt=0.
- Latency: exactly 2 pixclk_i cycles from input sample to output symbol for data and control. VDEn/hSync/vSync are delayed alongside the data so they stay aligned.
- Stage 1, registered. Per channel, with D = 8-bit component and N1(D) = popcount:
  - If N1(D)>4 or (N1(D)==4 and D[0]==0): XNOR chain. q_m[0]=D[0]; q_m[i]=q_m[i-1] XNOR D[i]; q_m[8]=0.
  - Else: XOR chain with the same form; q_m[8]=1.
  - Register q_m[8:0] together with DE, C0, C1.
- Stage 2, registered. Per channel, with N1 = ones in q_m[7:0], N0 = 8-N1, cnt = 5-bit signed (range -8..+8, even values only):
  - DE=0: output control token, cnt <= 0.
    - C1C0=00 -> 10'h354
    - 01 -> 10'h0AB
    - 10 -> 10'h154
    - 11 -> 10'h2AB
  - DE=1 and (cnt==0 or N1==N0):
    - out = {~q_m[8], q_m[8], q_m[8] ? q_m[7:0] : ~q_m[7:0]}.
    - cnt += q_m[8] ? (N1-N0) : (N0-N1).
  - DE=1 and ((cnt>0 and N1>N0) or (cnt<0 and N0>N1)):
    - out = {1, q_m[8], ~q_m[7:0]}.
    - cnt += 2*q_m[8] + (N0-N1).
  - Otherwise:
    - out = {0, q_m[8], q_m[7:0]}.
    - cnt += (N1-N0) - 2*(~q_m[8]).
- Control mapping:
  - Blue channel: C0 = hSync, C1 = vSync (after optional INVERT_SYNC).
  - Green and red channels: C1C0 = 00 always (no data islands/preambles; DVI only).
- Each channel's cnt is independent, and persists across consecutive active pixels within a line.
- Transition DE 0->1: the first active pixel encodes with cnt=0.
- Transition DE 1->0: cnt clears on the first control cycle.
- No X on outputs at any time after reset. Arithmetic is sized so cnt never wraps; ±8 is reachable and must be representable.

Test Plan:
- Reset: hold rstn_i=0, drive DE=1 and pixel=24'hFFFFFF -> all outputs 10'h354. Release, then 2 cycles later the first data symbol appears.
- Control tokens: DE=0, (hSync,vSync) = (0,0), (1,0), (0,1), (1,1) -> tmdsBlue_o = 354, 0AB, 154, 2AB. Red/green stay 354. Each output arrives 2 cycles after its input.
- DC balance on black: DE=1, pixel=24'h000000 for 2 cycles from cnt=0 -> blue symbols 10'h100 then 10'h3FF. cnt goes 0 -> -8 -> +2.
- White pixel: DE=1, pixel=24'hFFFFFF from cnt=0 -> each channel 10'h200, cnt=-8.
- Long random active line of 640 pixels:
  - Each output matches the reference model bit-exact.
  - Running sum of (ones − zeros) over all 10-bit symbols stays within ±12 throughout, and ends within ±8 before blanking.
  - Decoding every symbol recovers pixel_i delayed by 2 cycles.
- Mid-line reset: assert rstn_i asynchronously between edges during active video -> outputs 10'h354 immediately, without waiting for a clock edge. After release, an encode of 24'h000000 again yields 10'h100 (cnt restarted at 0).
